shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Arbitrates one single-port, synchronous-read block RAM (BIOS/DMEM-style, 1-cycle read latency) between two requesters: the CPU instruction-fetch port (IF, read-only) and the load/store data port (D, read/write with byte enables).
- Sits between the Riscv151 pipeline and the shared memory macro.
- Default priority goes to D. An anti-starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 12, word-address width of the shared RAM.
- DATA_W, 32, data width; must be 32 (4 byte lanes).
- MAX_STARVE, 4, consecutive denied IF-request cycles before IF gets priority (1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- if_req  input  1  IF read request
- if_addr  input  ADDR_W  IF word address
- if_gnt  output  1  IF request accepted this cycle (combinational)
- if_rvalid  output  1  IF read data valid (registered, one cycle after if_gnt)
- if_rdata  output  DATA_W  IF read data
- d_req  input  1  D request
- d_we  input  4  D byte write enables; 0 = read
- d_addr  input  ADDR_W  D word address
- d_wdata  input  DATA_W  D write data
- d_gnt  output  1  D request accepted this cycle (combinational)
- d_rvalid  output  1  D read data valid (registered, one cycle after a read d_gnt)
- d_rdata  output  DATA_W  D read data
- mem_en  output  1  RAM enable
- mem_we  output  4  RAM byte write enables
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en with mem_we = 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - if_rvalid = 0, d_rvalid = 0, starvation count = 0, state = PRI_D.
  - if_gnt, d_gnt, mem_en and mem_we forced to 0 while rst_n is low.
- Priority state machine:
  - States: PRI_D and PRI_IF.
  - Only one requester: it is granted regardless of state.
  - Both requesting: PRI_D grants D, PRI_IF grants IF.
  - Neither requesting: no grant, mem_en = 0.
- Starvation counter (4 bits):
  - Increments on each cycle with if_req = 1 and if_gnt = 0.
  - Cleared on any if_gnt.
  - When the count reaches MAX_STARVE, state goes to PRI_IF.
  - PRI_IF returns to PRI_D on the cycle after the IF grant.
  - Counter saturates; it never wraps.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_addr and mem_wdata come from the granted port.
  - mem_we = d_we when D is granted, else 0.
  - Exactly one grant per cycle, never both.
- Read return:
  - A registered "owner" tag records which port issued the read.
  - The next cycle asserts the matching rvalid for exactly one cycle.
  - if_rdata and d_rdata are wired directly to mem_rdata; they are qualified only by rvalid.
  - A D write (d_we != 0) produces no d_rvalid.
- Throughput: back-to-back grants are allowed every cycle; read latency is exactly 1 cycle.
- Requester rule: a requester holds req and addr stable until it sees gnt. A denied request is not queued inside the arbiter.
- Reset mid-operation: a pending rvalid is dropped (0 at the next edge after reset release); no spurious grant.
- Address ranges: arbiter is address-agnostic; both ports may target the same word. A D write and an IF read to the same address in the same cycle resolve by priority (write-then-read order follows grant order across cycles).

Optional Feature:
- Macro: SHARED_MEM_ARBITER_PERF_EN.
- When defined:
  - Adds outputs perf_conflicts (32) and perf_if_stalls (32).
  - perf_conflicts counts cycles with if_req & d_req.
  - perf_if_stalls counts cycles with if_req & !if_gnt.
  - Both reset to 0 and saturate at all-ones.
- When undefined: ports and counters are absent; the arbiter behaves identically otherwise.

Test Plan:
- Reset held 5 cycles with if_req = d_req = 1 -> all grants, rvalids and mem_en = 0; after release, first grant goes to D.
- IF alone reads addr 0x010, RAM holds 0x00000013 -> if_gnt same cycle; if_rvalid = 1 with if_rdata = 0x00000013 the next cycle; d_rvalid stays 0.
- D writes 0xDEADBEEF, d_we = 4'b0011, to addr 0x020, then reads 0x020 (RAM initially 0) -> mem_we = 0011 on the write; read returns 0x0000BEEF; one d_rvalid only, for the read.
- Both request continuously, MAX_STARVE = 4 -> D granted 4 cycles, IF granted on the 5th, then D again; pattern repeats with period 5.
- rst_n pulsed low the cycle after a D read grant -> d_rvalid never asserts; counter = 0 after release.
- With SHARED_MEM_ARBITER_PERF_EN, 10 cycles of dual requests -> perf_conflicts = 10, perf_if_stalls = 8.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// ============================================================================
// Module   : shared_mem_arbiter
// Purpose  : Two-port (IF read / D read-write) arbiter for one single-port,
//            1-cycle-latency block RAM; D has default priority and a
//            starvation counter guarantees IF forward progress.
//            Optional perf counters: define SHARED_MEM_ARBITER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SHARED_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_if_stalls
`endif
);

  localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);
  localparam logic [3:0] c_starve_sat = 4'hF;

  typedef enum logic [0:0] {
    PRI_D  = 1'b0,
    PRI_IF = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_starve;
  logic        r_if_rvalid;
  logic        r_d_rvalid;

  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_if_denied;
  logic [3:0]  w_starve_nxt;

  // Grants are forced low while reset is asserted, even with requests held.
  assign w_if_gnt    = rst_n & if_req & (~d_req | (r_state == PRI_IF));
  assign w_d_gnt     = rst_n & d_req & ~w_if_gnt;
  assign w_if_denied = if_req & ~w_if_gnt;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_if_gnt) begin
      w_starve_nxt = 4'h0;
    end else if (w_if_denied && (r_starve != c_starve_sat)) begin
      w_starve_nxt = r_starve + 4'h1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PRI_D;
      r_starve    <= 4'h0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_starve    <= w_starve_nxt;
      r_if_rvalid <= w_if_gnt;
      r_d_rvalid  <= w_d_gnt & (d_we == 4'h0);
      case (r_state)
        PRI_D: begin
          if (!w_if_gnt && (w_starve_nxt >= c_max_starve)) begin
            r_state <= PRI_IF;
          end
        end
        PRI_IF: begin
          if (w_if_gnt) begin
            r_state <= PRI_D;
          end
        end
        default: r_state <= PRI_D;
      endcase
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_en    = w_if_gnt | w_d_gnt;
  assign mem_we    = w_d_gnt ? d_we : 4'h0;
  assign mem_addr  = w_if_gnt ? if_addr : d_addr;
  assign mem_wdata = w_d_gnt ? d_wdata : '0;

`ifdef SHARED_MEM_ARBITER_PERF_EN
  logic [31:0] r_perf_conflicts;
  logic [31:0] r_perf_if_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_conflicts <= '0;
      r_perf_if_stalls <= '0;
    end else begin
      if (if_req && d_req && (r_perf_conflicts != '1)) begin
        r_perf_conflicts <= r_perf_conflicts + 32'd1;
      end
      if (w_if_denied && (r_perf_if_stalls != '1)) begin
        r_perf_if_stalls <= r_perf_if_stalls + 32'd1;
      end
    end
  end

  assign perf_conflicts = r_perf_conflicts;
  assign perf_if_stalls = r_perf_if_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
// ============================================================================
// Module   : tb_shared_mem_arbiter
// Purpose  : Directed, table-driven bench for shared_mem_arbiter with a
//            behavioural byte-enabled 1-cycle-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic [3:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef SHARED_MEM_ARBITER_PERF_EN
  logic [31:0]       perf_conflicts;
  logic [31:0]       perf_if_stalls;
`endif

  int n_checks = 0;
  int n_errors = 0;

  shared_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_STARVE(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef SHARED_MEM_ARBITER_PERF_EN
    ,
    .perf_conflicts(perf_conflicts),
    .perf_if_stalls(perf_if_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous read, byte-lane writes.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) begin
        mem_rdata <= ram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              e_if_gnt;
    logic              e_d_gnt;
    logic [3:0]        e_mem_we;
    logic [ADDR_W-1:0] e_mem_addr;
    logic [DATA_W-1:0] e_mem_wdata;
    logic              e_if_rvalid;
    logic              e_d_rvalid;
    logic [DATA_W-1:0] e_rdata;
  } vec_t;

  vec_t vt [12];

  initial begin
    for (int a = 0; a < (1<<ADDR_W); a++) ram[a] = '0;
    ram[12'h010] = 32'h0000_0013;
    mem_rdata = '0;

    // IF read, D partial write, D read-back, mixed conflicts, write-then-read.
    vt[0]  = '{1'b1, 12'h010, 1'b0, 4'h0, '0,      '0,           1'b1, 1'b0, 4'h0, 12'h010, '0,           1'b0, 1'b0, '0};
    vt[1]  = '{1'b0, '0,      1'b1, 4'h3, 12'h020, 32'hDEADBEEF, 1'b0, 1'b1, 4'h3, 12'h020, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0000_0013};
    vt[2]  = '{1'b0, '0,      1'b1, 4'h0, 12'h020, '0,           1'b0, 1'b1, 4'h0, 12'h020, '0,           1'b0, 1'b0, '0};
    vt[3]  = '{1'b0, '0,      1'b0, 4'h0, '0,      '0,           1'b0, 1'b0, 4'h0, '0,      '0,           1'b0, 1'b1, 32'h0000_BEEF};
    vt[4]  = '{1'b0, '0,      1'b0, 4'h0, '0,      '0,           1'b0, 1'b0, 4'h0, '0,      '0,           1'b0, 1'b0, '0};
    vt[5]  = '{1'b1, 12'h010, 1'b1, 4'hC, 12'h030, 32'hCAFEF00D, 1'b0, 1'b1, 4'hC, 12'h030, 32'hCAFEF00D, 1'b0, 1'b0, '0};
    vt[6]  = '{1'b0, '0,      1'b1, 4'h0, 12'h030, '0,           1'b0, 1'b1, 4'h0, 12'h030, '0,           1'b0, 1'b0, '0};
    vt[7]  = '{1'b0, '0,      1'b0, 4'h0, '0,      '0,           1'b0, 1'b0, 4'h0, '0,      '0,           1'b0, 1'b1, 32'hCAFE_0000};
    vt[8]  = '{1'b1, 12'h030, 1'b0, 4'h0, '0,      '0,           1'b1, 1'b0, 4'h0, 12'h030, '0,           1'b0, 1'b0, '0};
    vt[9]  = '{1'b1, 12'h040, 1'b1, 4'hF, 12'h040, 32'h12345678, 1'b0, 1'b1, 4'hF, 12'h040, 32'h12345678, 1'b1, 1'b0, 32'hCAFE_0000};
    vt[10] = '{1'b1, 12'h040, 1'b0, 4'h0, '0,      '0,           1'b1, 1'b0, 4'h0, 12'h040, '0,           1'b0, 1'b0, '0};
    vt[11] = '{1'b0, '0,      1'b0, 4'h0, '0,      '0,           1'b0, 1'b0, 4'h0, '0,      '0,           1'b1, 1'b0, 32'h1234_5678};

    // Reset held with both requests asserted.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 12'h100;
    d_req = 1'b1; d_we = 4'h0; d_addr = 12'h200; d_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Continuous dual requests: D x4 then IF, period 5.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pat_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
      check("pat_d_gnt", 32'(d_gnt), 32'((k % 5) != 4));
      check("pat_mem_addr", 32'(mem_addr), ((k % 5) == 4) ? 32'h100 : 32'h200);
      check("pat_if_rvalid", 32'(if_rvalid), 32'((k > 0) && (((k - 1) % 5) == 4)));
      check("pat_d_rvalid", 32'(d_rvalid), 32'((k > 0) && (((k - 1) % 5) != 4)));
    end
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("last_if_rvalid", 32'(if_rvalid), 32'd1);
    check("last_d_rvalid", 32'(d_rvalid), 32'd0);
`ifdef SHARED_MEM_ARBITER_PERF_EN
    check("perf_conflicts", perf_conflicts, 32'd10);
    check("perf_if_stalls", perf_if_stalls, 32'd8);
`endif
    @(posedge clk);
    @(negedge clk);
    check("idle_if_rvalid", 32'(if_rvalid), 32'd0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
      @(negedge clk);
      check($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vt[i].e_if_gnt));
      check($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vt[i].e_d_gnt));
      check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vt[i].e_if_gnt | vt[i].e_d_gnt));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_mem_we));
      if (vt[i].e_if_gnt || vt[i].e_d_gnt)
        check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_mem_addr));
      if (vt[i].e_mem_we != 4'h0)
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_mem_wdata);
      check($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vt[i].e_if_rvalid));
      check($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(vt[i].e_d_rvalid));
      if (vt[i].e_if_rvalid) check($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].e_rdata);
      if (vt[i].e_d_rvalid)  check($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].e_rdata);
    end

    // Reset pulsed right after a D read grant, with IF starvation pending.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 12'h010; d_req = 1'b1; d_we = 4'h0; d_addr = 12'h020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
    check("mid_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) check("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check("post_rst_d_gnt", 32'(d_gnt), 32'(k != 4));
      check("post_rst_if_gnt", 32'(if_gnt), 32'(k == 4));
    end
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("final_if_rvalid", 32'(if_rvalid), 32'd1);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
